// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store sequencer: bus widths
// and the FSM state encoding.
package mem_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 8;

   typedef logic [1:0] mem_state_t;

   localparam mem_state_t IDLE  = 2'd0;
   localparam mem_state_t BYTE0 = 2'd1;
   localparam mem_state_t BYTE1 = 2'd2;
   localparam mem_state_t DONE  = 2'd3;

   function automatic logic is_bus_state(input mem_state_t st);
      return (st == BYTE0) || (st == BYTE1);
   endfunction

endpackage

// File: rtl/mem_ld_st_unit.sv
// Memory-stage load/store sequencer: moves one or two bytes per operation over
// an 8-bit req/ack data-memory bus and stalls the pipeline while busy.
//
// state | meaning
// IDLE  | waiting for op_valid; op fields latched on acceptance
// BYTE0 | low byte transfer at addr, waiting for mem_ack
// BYTE1 | high byte transfer at addr+1 (wraps), word ops only
// DONE  | ld_done pulse; pipeline released; returns to IDLE
module mem_ld_st_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  op_valid,
   input  logic                  op_is_store,
   input  logic                  op_is_word,
   input  logic [ADDR_WIDTH-1:0] op_addr,
   input  logic [DATA_WIDTH-1:0] st_data_top,
   input  logic [DATA_WIDTH-1:0] st_data_bot,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [DATA_WIDTH-1:0] ld_res_top,
   output logic [DATA_WIDTH-1:0] ld_res_bot,
   output logic                  ld_done,
   output logic                  stall
);

   mem_state_t state_q;
   mem_state_t state_d;

   logic                  lat_is_store;
   logic                  lat_is_word;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_top;
   logic [DATA_WIDTH-1:0] lo_buf;

   logic accept;
   logic ack_q;
   logic we_src;

   assign accept = (state_q == IDLE) && op_valid;
   assign ack_q  = mem_ack && mem_req && is_bus_state(state_q);
   assign we_src = (state_q == IDLE) ? op_is_store : lat_is_store;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (op_valid) state_d = BYTE0;
         BYTE0:   if (ack_q)    state_d = lat_is_word ? BYTE1 : DONE;
         BYTE1:   if (ack_q)    state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_comb begin
      stall   = 1'b0;
      ld_done = 1'b0;
      case (state_q)
         IDLE:    stall   = op_valid;
         BYTE0:   stall   = 1'b1;
         BYTE1:   stall   = 1'b1;
         DONE:    ld_done = 1'b1;
         default: stall   = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat_is_store <= 1'b0;
         lat_is_word  <= 1'b0;
         lat_addr     <= '0;
         lat_top      <= '0;
      end else if (accept) begin
         lat_is_store <= op_is_store;
         lat_is_word  <= op_is_word;
         lat_addr     <= op_addr;
         lat_top      <= st_data_top;
      end
   end

   // Bus outputs are registered off the next state so they line up with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_req <= is_bus_state(state_d);
         mem_we  <= is_bus_state(state_d) && we_src;
         if (accept) begin
            mem_addr  <= op_addr;
            mem_wdata <= st_data_bot;
         end else if ((state_q == BYTE0) && ack_q && lat_is_word) begin
            mem_addr  <= lat_addr + ADDR_WIDTH'(1);
            mem_wdata <= lat_top;
         end
      end
   end

   // Word loads buffer the low byte so both result bytes change together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lo_buf     <= '0;
         ld_res_top <= '0;
         ld_res_bot <= '0;
      end else if (ack_q && !lat_is_store) begin
         if (state_q == BYTE0) begin
            if (lat_is_word) begin
               lo_buf <= mem_rdata;
            end else begin
               ld_res_bot <= mem_rdata;
               ld_res_top <= '0;
            end
         end else if (state_q == BYTE1) begin
            ld_res_bot <= lo_buf;
            ld_res_top <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_ld_st_unit.sv
// Directed bench for mem_ld_st_unit: loads, stores, wait states, address
// wrap, latching, mid-transfer reset and spurious acks.
module tb_mem_ld_st_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        op_valid, op_is_store, op_is_word;
   logic [15:0] op_addr;
   logic [7:0]  st_data_top, st_data_bot;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;
   logic [7:0]  ld_res_top, ld_res_bot;
   logic        ld_done, stall;

   int tests  = 0;
   int failed = 0;
   int stall_n;
   int done_n;

   mem_ld_st_unit dut (
      .clock(clock), .reset_n(reset_n),
      .op_valid(op_valid), .op_is_store(op_is_store), .op_is_word(op_is_word),
      .op_addr(op_addr), .st_data_top(st_data_top), .st_data_bot(st_data_bot),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ld_res_top(ld_res_top), .ld_res_bot(ld_res_bot),
      .ld_done(ld_done), .stall(stall)
   );

   always #5 clock = ~clock;

   // Sample combinational outputs mid-cycle, then advance to just past the next edge.
   task automatic cyc();
      #1;
      if (stall)   stall_n++;
      if (ld_done) done_n++;
      @(posedge clock);
      #1;
   endtask

   task automatic start_op(input logic st, input logic wd, input logic [15:0] a,
                           input logic [7:0] top, input logic [7:0] bot);
      op_valid = 1'b1; op_is_store = st; op_is_word = wd; op_addr = a;
      st_data_top = top; st_data_bot = bot;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL rst_req got=%0b exp=0", mem_req); end
      tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
      tests++; if (mem_addr !== 16'h0000) begin failed++; $display("FAIL rst_addr got=%h exp=0000", mem_addr); end
      tests++; if (mem_wdata !== 8'h00) begin failed++; $display("FAIL rst_wdata got=%h exp=00", mem_wdata); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h0000) begin failed++; $display("FAIL rst_res got=%h exp=0000", {ld_res_top, ld_res_bot}); end
      tests++; if (ld_done !== 1'b0) begin failed++; $display("FAIL rst_done got=%0b exp=0", ld_done); end
      tests++; if (stall !== 1'b0) begin failed++; $display("FAIL rst_stall0 got=%0b exp=0", stall); end
      op_valid = 1'b1;
      #1;
      tests++; if (stall !== 1'b1) begin failed++; $display("FAIL rst_stall_valid got=%0b exp=1", stall); end
      op_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      cyc();
      tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL rst_release_req got=%0b exp=0", mem_req); end
   endtask

   task automatic test_byte_load();
      stall_n = 0; done_n = 0;
      start_op(1'b0, 1'b0, 16'h1234, 8'h00, 8'h00);
      cyc();
      tests++; if ({mem_req, mem_we} !== 2'b10) begin failed++; $display("FAIL bl_req_we got=%b exp=10", {mem_req, mem_we}); end
      tests++; if (mem_addr !== 16'h1234) begin failed++; $display("FAIL bl_addr got=%h exp=1234", mem_addr); end
      op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hA5;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      #1;
      tests++; if (ld_done !== 1'b1) begin failed++; $display("FAIL bl_done_cycle2 got=%0b exp=1", ld_done); end
      tests++; if (stall !== 1'b0) begin failed++; $display("FAIL bl_stall_done got=%0b exp=0", stall); end
      tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL bl_req_done got=%0b exp=0", mem_req); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h00A5) begin failed++; $display("FAIL bl_res got=%h exp=00a5", {ld_res_top, ld_res_bot}); end
      cyc();
      tests++; if (ld_done !== 1'b0) begin failed++; $display("FAIL bl_done_clear got=%0b exp=0", ld_done); end
      tests++; if (stall_n !== 2) begin failed++; $display("FAIL bl_stall_cycles got=%0d exp=2", stall_n); end
      tests++; if (done_n !== 1) begin failed++; $display("FAIL bl_done_count got=%0d exp=1", done_n); end
   endtask

   task automatic test_word_load_wait();
      stall_n = 0; done_n = 0;
      start_op(1'b0, 1'b1, 16'h0040, 8'h00, 8'h00);
      cyc();
      op_valid = 1'b0;
      tests++; if (mem_addr !== 16'h0040) begin failed++; $display("FAIL wl_addr0 got=%h exp=0040", mem_addr); end
      cyc(); cyc();
      tests++; if (mem_req !== 1'b1) begin failed++; $display("FAIL wl_req_wait got=%0b exp=1", mem_req); end
      mem_ack = 1'b1; mem_rdata = 8'h34;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if (mem_addr !== 16'h0041) begin failed++; $display("FAIL wl_addr1 got=%h exp=0041", mem_addr); end
      tests++; if ({mem_req, mem_we} !== 2'b10) begin failed++; $display("FAIL wl_req_we1 got=%b exp=10", {mem_req, mem_we}); end
      cyc(); cyc();
      mem_ack = 1'b1; mem_rdata = 8'h12;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h1234) begin failed++; $display("FAIL wl_res got=%h exp=1234", {ld_res_top, ld_res_bot}); end
      tests++; if (ld_done !== 1'b1) begin failed++; $display("FAIL wl_done got=%0b exp=1", ld_done); end
      cyc();
      tests++; if (stall_n !== 7) begin failed++; $display("FAIL wl_stall_cycles got=%0d exp=7", stall_n); end
   endtask

   task automatic test_word_store_wrap();
      start_op(1'b1, 1'b1, 16'hFFFF, 8'hBE, 8'hEF);
      cyc();
      op_valid = 1'b0;
      tests++; if ({mem_addr, mem_wdata} !== 24'hFFFF_EF) begin failed++; $display("FAIL ws_beat0 got=%h exp=ffffef", {mem_addr, mem_wdata}); end
      tests++; if ({mem_req, mem_we} !== 2'b11) begin failed++; $display("FAIL ws_we0 got=%b exp=11", {mem_req, mem_we}); end
      mem_ack = 1'b1; mem_rdata = 8'h99;
      cyc();
      tests++; if ({mem_addr, mem_wdata} !== 24'h0000_BE) begin failed++; $display("FAIL ws_beat1_wrap got=%h exp=0000be", {mem_addr, mem_wdata}); end
      tests++; if ({mem_req, mem_we} !== 2'b11) begin failed++; $display("FAIL ws_we1 got=%b exp=11", {mem_req, mem_we}); end
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if ({mem_req, mem_we} !== 2'b00) begin failed++; $display("FAIL ws_we_done got=%b exp=00", {mem_req, mem_we}); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h1234) begin failed++; $display("FAIL ws_res_hold got=%h exp=1234", {ld_res_top, ld_res_bot}); end
      tests++; if (ld_done !== 1'b1) begin failed++; $display("FAIL ws_done got=%0b exp=1", ld_done); end
      cyc();
   endtask

   task automatic test_latch_ignore();
      start_op(1'b0, 1'b0, 16'h0100, 8'h00, 8'h00);
      cyc();
      op_valid = 1'b0; op_addr = 16'h0200; op_is_word = 1'b1;
      cyc();
      op_valid = 1'b1;
      cyc();
      tests++; if (mem_addr !== 16'h0100) begin failed++; $display("FAIL li_addr_latched got=%h exp=0100", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      // Byte op latched; the later op_is_word change must not add a second beat.
      tests++; if (ld_done !== 1'b1) begin failed++; $display("FAIL li_done got=%0b exp=1", ld_done); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h005A) begin failed++; $display("FAIL li_res got=%h exp=005a", {ld_res_top, ld_res_bot}); end
      start_op(1'b0, 1'b0, 16'h0300, 8'h00, 8'h00);
      #1;
      tests++; if (stall !== 1'b0) begin failed++; $display("FAIL li_stall_done got=%0b exp=0", stall); end
      cyc();
      tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL li_no_accept_done got=%0b exp=0", mem_req); end
      cyc();
      op_valid = 1'b0;
      tests++; if ({mem_req, mem_addr} !== 17'h1_0300) begin failed++; $display("FAIL li_b2b_accept got=%h exp=10300", {mem_req, mem_addr}); end
      mem_ack = 1'b1; mem_rdata = 8'h77;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h0077) begin failed++; $display("FAIL li_b2b_res got=%h exp=0077", {ld_res_top, ld_res_bot}); end
      cyc();
   endtask

   task automatic test_reset_mid();
      done_n = 0;
      start_op(1'b0, 1'b1, 16'h0800, 8'h00, 8'h00);
      cyc();
      op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h11;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if ({mem_req, mem_addr} !== 17'h1_0801) begin failed++; $display("FAIL rm_in_byte1 got=%h exp=10801", {mem_req, mem_addr}); end
      reset_n = 1'b0;
      #1;
      tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL rm_req_drop got=%0b exp=0", mem_req); end
      tests++; if ({mem_addr, mem_wdata, mem_we} !== 25'h0) begin failed++; $display("FAIL rm_bus_zero got=%h exp=0", {mem_addr, mem_wdata, mem_we}); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h0000) begin failed++; $display("FAIL rm_res_zero got=%h exp=0000", {ld_res_top, ld_res_bot}); end
      tests++; if ({ld_done, stall} !== 2'b00) begin failed++; $display("FAIL rm_done_stall got=%b exp=00", {ld_done, stall}); end
      cyc(); cyc();
      reset_n = 1'b1;
      cyc(); cyc();
      tests++; if (done_n !== 0) begin failed++; $display("FAIL rm_no_done got=%0d exp=0", done_n); end
      start_op(1'b0, 1'b0, 16'h0002, 8'h00, 8'h00);
      cyc();
      op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
      cyc();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tests++; if ({ld_done, ld_res_top, ld_res_bot} !== 17'h1_00C3) begin failed++; $display("FAIL rm_after_load got=%h exp=100c3", {ld_done, ld_res_top, ld_res_bot}); end
      cyc();
   endtask

   task automatic test_spurious_ack();
      mem_ack = 1'b1; mem_rdata = 8'hFF;
      cyc(); cyc();
      tests++; if ({mem_req, ld_done, stall} !== 3'b000) begin failed++; $display("FAIL sa_idle_ctrl got=%b exp=000", {mem_req, ld_done, stall}); end
      tests++; if ({ld_res_top, ld_res_bot} !== 16'h00C3) begin failed++; $display("FAIL sa_idle_res got=%h exp=00c3", {ld_res_top, ld_res_bot}); end
      start_op(1'b0, 1'b0, 16'h0003, 8'h00, 8'h00);
      mem_rdata = 8'h66;
      cyc();
      op_valid = 1'b0;
      cyc();
      mem_rdata = 8'hEE;
      tests++; if ({ld_done, ld_res_bot} !== 9'h166) begin failed++; $display("FAIL sa_load got=%h exp=166", {ld_done, ld_res_bot}); end
      cyc();
      tests++; if ({mem_req, ld_done, ld_res_bot} !== 10'h066) begin failed++; $display("FAIL sa_done_ack got=%h exp=066", {mem_req, ld_done, ld_res_bot}); end
      cyc();
      tests++; if ({mem_req, ld_done, ld_res_bot} !== 10'h066) begin failed++; $display("FAIL sa_after got=%h exp=066", {mem_req, ld_done, ld_res_bot}); end
      mem_ack = 1'b0; mem_rdata = 8'h00;
   endtask

   initial begin
      op_valid = 1'b0; op_is_store = 1'b0; op_is_word = 1'b0; op_addr = '0;
      st_data_top = '0; st_data_bot = '0; mem_rdata = '0; mem_ack = 1'b0;
      stall_n = 0; done_n = 0;
      test_reset();
      test_byte_load();
      test_word_load_wait();
      test_word_store_wrap();
      test_latch_ignore();
      test_reset_mid();
      test_spurious_ack();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
